// File: rtl/buble_ctrl_stage_pkg.sv
// Shared types for the bubble-insertion stage: control-word layout and its inert value.
package buble_pkg;
  localparam int FWD_W = 2;

  typedef struct packed {
    logic             w_enable;
    logic             alu_ctrl;
    logic             r_i_sel_ctrl;
    logic             rd_ctrl;
    logic             wd_ctrl;
    logic             wb_mux_ctrl;
    logic             fwd_dm_ctrl;
    logic             beq_and_in2;
    logic [FWD_W-1:0] fwd_ctrl_a;
    logic [FWD_W-1:0] fwd_ctrl_b;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/buble_ctrl_stage_if.sv
// Control-word bus between hazard/decode and the bubble stage.
// Optional stats ports appear when BUBLE_STAT_EN is defined.
interface buble_if #(parameter int FWD_W = buble_pkg::FWD_W);
  logic             en, buble_mux_ctrl;
  logic             w_enable, alu_ctrl, r_i_sel_ctrl, rd_ctrl;
  logic             wd_ctrl, wb_mux_ctrl, fwd_dm_ctrl, beq_and_in2;
  logic [FWD_W-1:0] fwd_ctrl_a, fwd_ctrl_b;
  logic             o_w_enable, o_alu_ctrl, o_r_i_sel_ctrl, o_rd_ctrl;
  logic             o_wd_ctrl, o_wb_mux_ctrl, o_fwd_dm_ctrl, o_beq_and_in2;
  logic [FWD_W-1:0] o_fwd_ctrl_a, o_fwd_ctrl_b;
`ifdef BUBLE_STAT_EN
  logic [15:0]      o_bubble_cnt;
  logic             o_bubble;
`endif

  modport master (
    output en, buble_mux_ctrl, w_enable, alu_ctrl, r_i_sel_ctrl, rd_ctrl,
           wd_ctrl, wb_mux_ctrl, fwd_dm_ctrl, beq_and_in2, fwd_ctrl_a, fwd_ctrl_b,
    input  o_w_enable, o_alu_ctrl, o_r_i_sel_ctrl, o_rd_ctrl, o_wd_ctrl,
           o_wb_mux_ctrl, o_fwd_dm_ctrl, o_beq_and_in2, o_fwd_ctrl_a, o_fwd_ctrl_b
`ifdef BUBLE_STAT_EN
    , input o_bubble_cnt, o_bubble
`endif
  );

  modport slave (
    input  en, buble_mux_ctrl, w_enable, alu_ctrl, r_i_sel_ctrl, rd_ctrl,
           wd_ctrl, wb_mux_ctrl, fwd_dm_ctrl, beq_and_in2, fwd_ctrl_a, fwd_ctrl_b,
    output o_w_enable, o_alu_ctrl, o_r_i_sel_ctrl, o_rd_ctrl, o_wd_ctrl,
           o_wb_mux_ctrl, o_fwd_dm_ctrl, o_beq_and_in2, o_fwd_ctrl_a, o_fwd_ctrl_b
`ifdef BUBLE_STAT_EN
    , output o_bubble_cnt, o_bubble
`endif
  );
endinterface

// File: rtl/buble_ctrl_stage_mux.sv
// Combinational bubble select. Anything but a clean 1 on sel yields the inert word,
// so an undriven select can never leak X into the execute stage.
module buble_mux
  import buble_pkg::*;
(
  input  logic       sel,
  input  ctrl_word_t ctrl_in,
  output ctrl_word_t ctrl_out,
  output logic       pass
);
  assign pass     = (sel === 1'b1);
  assign ctrl_out = pass ? ctrl_in : CTRL_BUBBLE;
endmodule

// File: rtl/buble_ctrl_stage.sv
// Registered bubble-insertion stage for the execute control word.
// Define BUBLE_STAT_EN to add the bubble counter and bubble flag outputs.
module buble_ctrl_stage
  import buble_pkg::*;
#(
  parameter int FWD_W = buble_pkg::FWD_W
) (
  input  logic   clk,
  input  logic   rst,
  buble_if.slave bus
);
  // Control-word layout is fixed by the package; reject mismatched overrides.
  if (FWD_W != buble_pkg::FWD_W) begin : g_bad_fwd_w
    $error("buble_ctrl_stage: FWD_W must match buble_pkg::FWD_W");
  end

  ctrl_word_t ctrl_in, ctrl_sel, ctrl_q;
  logic       pass;

  assign ctrl_in = '{
    w_enable:     bus.w_enable,
    alu_ctrl:     bus.alu_ctrl,
    r_i_sel_ctrl: bus.r_i_sel_ctrl,
    rd_ctrl:      bus.rd_ctrl,
    wd_ctrl:      bus.wd_ctrl,
    wb_mux_ctrl:  bus.wb_mux_ctrl,
    fwd_dm_ctrl:  bus.fwd_dm_ctrl,
    beq_and_in2:  bus.beq_and_in2,
    fwd_ctrl_a:   bus.fwd_ctrl_a,
    fwd_ctrl_b:   bus.fwd_ctrl_b
  };

  buble_mux u_mux (
    .sel      (bus.buble_mux_ctrl),
    .ctrl_in  (ctrl_in),
    .ctrl_out (ctrl_sel),
    .pass     (pass)
  );

  always_ff @(posedge clk) begin
    if (rst)         ctrl_q <= CTRL_BUBBLE;
    else if (bus.en) ctrl_q <= ctrl_sel;
  end

  assign bus.o_w_enable     = ctrl_q.w_enable;
  assign bus.o_alu_ctrl     = ctrl_q.alu_ctrl;
  assign bus.o_r_i_sel_ctrl = ctrl_q.r_i_sel_ctrl;
  assign bus.o_rd_ctrl      = ctrl_q.rd_ctrl;
  assign bus.o_wd_ctrl      = ctrl_q.wd_ctrl;
  assign bus.o_wb_mux_ctrl  = ctrl_q.wb_mux_ctrl;
  assign bus.o_fwd_dm_ctrl  = ctrl_q.fwd_dm_ctrl;
  assign bus.o_beq_and_in2  = ctrl_q.beq_and_in2;
  assign bus.o_fwd_ctrl_a   = ctrl_q.fwd_ctrl_a;
  assign bus.o_fwd_ctrl_b   = ctrl_q.fwd_ctrl_b;

`ifdef BUBLE_STAT_EN
  logic [15:0] bubble_cnt;
  logic        bubble_q;

  // Only advancing edges count; stalled cycles re-present the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      bubble_q   <= 1'b0;
    end else if (bus.en) begin
      bubble_q <= ~pass;
      if (!pass && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign bus.o_bubble_cnt = bubble_cnt;
  assign bus.o_bubble     = bubble_q;
`endif
endmodule

// File: tb/tb_buble_ctrl_stage.sv
// Directed bench for buble_ctrl_stage; X-propagation steps run only on 4-state simulators.
module tb_buble_ctrl_stage;
  import buble_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic probe;
  bit   four_state;

  always #5 clk = ~clk;

  buble_if #(.FWD_W(2)) bus ();

  buble_ctrl_stage #(.FWD_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [11:0] obs_word();
    return {bus.o_w_enable, bus.o_alu_ctrl, bus.o_r_i_sel_ctrl, bus.o_rd_ctrl,
            bus.o_wd_ctrl, bus.o_wb_mux_ctrl, bus.o_fwd_dm_ctrl, bus.o_beq_and_in2,
            bus.o_fwd_ctrl_a, bus.o_fwd_ctrl_b};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // w = {8 single-bit controls MSB-first, fwd_a, fwd_b}
  task automatic drive(input logic e, input logic sel, input logic [11:0] w);
    bus.en             = e;
    bus.buble_mux_ctrl = sel;
    {bus.w_enable, bus.alu_ctrl, bus.r_i_sel_ctrl, bus.rd_ctrl,
     bus.wd_ctrl, bus.wb_mux_ctrl, bus.fwd_dm_ctrl, bus.beq_and_in2,
     bus.fwd_ctrl_a, bus.fwd_ctrl_b} = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    probe      = 1'bx;
    four_state = $isunknown(probe);

    // reset with all inputs active
    rst = 1'b1;
    drive(1'b1, 1'b1, 12'hFFA);
    step();
    chk("reset", {4'h0, obs_word()}, 16'h0000);
`ifdef BUBLE_STAT_EN
    chk("reset_cnt", bus.o_bubble_cnt, 16'd0);
    chk("reset_flag", {15'd0, bus.o_bubble}, 16'd0);
`endif

    // pass-through
    rst = 1'b0;
    step();
    chk("pass_ones", {4'h0, obs_word()}, 16'h0FFA);

    // bubble beats data
    drive(1'b1, 1'b0, 12'hFFA);
    step();
    chk("bubble", {4'h0, obs_word()}, 16'h0000);
`ifdef BUBLE_STAT_EN
    chk("bubble_cnt1", bus.o_bubble_cnt, 16'd1);
    chk("bubble_flag1", {15'd0, bus.o_bubble}, 16'd1);
`endif

    // alternating pattern, distinct fwd fields
    drive(1'b1, 1'b1, 12'hAA7);
    step();
    chk("pass_aa7", {4'h0, obs_word()}, 16'h0AA7);
`ifdef BUBLE_STAT_EN
    chk("pass_flag0", {15'd0, bus.o_bubble}, 16'd0);
`endif
    drive(1'b1, 1'b1, 12'h558);
    step();
    chk("pass_558", {4'h0, obs_word()}, 16'h0558);

    // stall: en=0 with bubble request holds the last word
    drive(1'b1, 1'b1, 12'hFFA);
    step();
    chk("stall_load", {4'h0, obs_word()}, 16'h0FFA);
    drive(1'b0, 1'b0, 12'h000);
    step();
    chk("stall_hold1", {4'h0, obs_word()}, 16'h0FFA);
    step();
    chk("stall_hold2", {4'h0, obs_word()}, 16'h0FFA);
    step();
    chk("stall_hold3", {4'h0, obs_word()}, 16'h0FFA);
`ifdef BUBLE_STAT_EN
    chk("stall_cnt", bus.o_bubble_cnt, 16'd1);
`endif

    // reset beats stall
    rst = 1'b1;
    step();
    chk("rst_over_stall", {4'h0, obs_word()}, 16'h0000);
    rst = 1'b0;

    // bubble masks arbitrary data
    drive(1'b1, 1'b1, 12'hFFA);
    step();
    drive(1'b1, 1'b0, 12'h5A5);
    step();
    chk("bubble_mask", {4'h0, obs_word()}, 16'h0000);

    if (four_state) begin
      // X select inserts a clean bubble
      drive(1'b1, 1'b1, 12'hFFA);
      step();
      bus.buble_mux_ctrl = 1'bx;
      step();
      chk("xsel_zero", {4'h0, obs_word()}, 16'h0000);
      chk("xsel_known", {15'd0, $isunknown(obs_word())}, 16'd0);

      // X on some data bits passes through on select=1
      drive(1'b1, 1'b1, 12'hFFA);
      bus.w_enable = 1'bx;  bus.r_i_sel_ctrl = 1'bx;
      bus.rd_ctrl  = 1'bx;  bus.fwd_dm_ctrl  = 1'bx;
      bus.fwd_ctrl_a = 2'bxx;
      step();
      chk("xdata_known", {4'h0, bus.o_alu_ctrl, bus.o_wd_ctrl, bus.o_wb_mux_ctrl,
          bus.o_beq_and_in2, 6'd0, bus.o_fwd_ctrl_b}, 16'h0F02);
      chk("xdata_x", {10'd0, bus.o_w_enable, bus.o_r_i_sel_ctrl, bus.o_rd_ctrl,
          bus.o_fwd_dm_ctrl, bus.o_fwd_ctrl_a}, {10'd0, 6'bxxxxxx});
      bus.buble_mux_ctrl = 1'b0;
      step();
      chk("xdata_bubble", {4'h0, obs_word()}, 16'h0000);
    end

`ifdef BUBLE_STAT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 12'hFFA);
    repeat (5) step();
    chk("stat_cnt5", bus.o_bubble_cnt, 16'd5);
    drive(1'b0, 1'b0, 12'hFFA);
    step();
    chk("stat_stall", bus.o_bubble_cnt, 16'd5);
    rst = 1'b1;
    step();
    chk("stat_clear", bus.o_bubble_cnt, 16'd0);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/buble_ctrl_stage.md
Name: buble_ctrl_stage

Overview:
- Pipeline bubble-insertion stage for the control word of the 32-bit RISC-style core.
- Sits between decode/hazard-detection and the execute-stage control register.
- When the hazard unit requests a bubble, every control signal is forced to its inert value (0) so the downstream stage performs a NOP.
- Output is registered: one-cycle latency, synchronous active-high reset.

Parameters:
- FWD_W, 2, width of each forwarding-select field (fwd_ctrl_a / fwd_ctrl_b).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  stage advance; 0 holds the current outputs (pipeline stall)
- buble_mux_ctrl  in  1  1 = pass control word; 0 = insert bubble
- w_enable  in  1  register-file write enable
- alu_ctrl  in  1  ALU operation select
- r_i_sel_ctrl  in  1  R/I operand select
- rd_ctrl  in  1  destination-register select
- wd_ctrl  in  1  data-memory write enable
- wb_mux_ctrl  in  1  write-back mux select
- fwd_dm_ctrl  in  1  data-memory forwarding select
- beq_and_in2  in  1  branch-equal enable into branch AND gate
- fwd_ctrl_a  in  FWD_W  operand-A forwarding select
- fwd_ctrl_b  in  FWD_W  operand-B forwarding select
- o_w_enable, o_alu_ctrl, o_r_i_sel_ctrl, o_rd_ctrl, o_wd_ctrl, o_wb_mux_ctrl, o_fwd_dm_ctrl, o_beq_and_in2  out  1 each  registered gated copies of the inputs
- o_fwd_ctrl_a, o_fwd_ctrl_b  out  FWD_W each  registered gated copies of the inputs

Behaviour:
- Clocking and reset are as stated in the Ports section: one clock (clk, rising edge) and synchronous, active-high reset (rst).
- Reset: on a rising edge with rst=1, all outputs become 0. rst has priority over en and buble_mux_ctrl.
- Normal advance: on a rising edge with rst=0, en=1 and buble_mux_ctrl=1, each output register loads its corresponding input unchanged.
- Bubble: on a rising edge with rst=0, en=1 and buble_mux_ctrl=0, all outputs load 0 (all 1-bit outputs 0, forwarding fields 2'b00), regardless of the other inputs.
- Unknown select: if buble_mux_ctrl is anything other than exactly 1'b1 (X or Z), the stage inserts a bubble. The select must be decoded with a case-equality style check so that X never propagates to the outputs.
- Stall: with en=0 and rst=0, outputs hold their previous values.
- Input X values on data inputs during a bubble must not reach the outputs.
- Latency is exactly 1 cycle from input to output. There is no combinational path from inputs to outputs.
- Simultaneous events: rst beats en=0; en=0 beats bubble; bubble beats data.

Optional Feature:
- Macro: BUBLE_STAT_EN.
- With the macro defined:
  - Add output o_bubble_cnt, 16 bits.
  - The counter increments on every clock edge that actually inserts a bubble (rst=0, en=1, select not 1'b1).
  - It saturates at 16'hFFFF and clears to 0 on rst.
  - Add output o_bubble, 1 bit: registered flag that is 1 when the current outputs came from a bubble.
- Without the macro: neither port nor the counter logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package buble_pkg holds:
  - FWD_W;
  - a packed struct ctrl_word_t grouping the 8 single-bit controls and the two forwarding fields;
  - a constant CTRL_BUBBLE = all-zero ctrl_word_t.
- One natural sub-module, buble_mux: a purely combinational select between the input control word and CTRL_BUBBLE, including the X-safe decode.
- The top level adds the enable/reset register and the optional statistics logic.

Test Plan:
- Reset: assert rst with all inputs 1 and fwd=2'b10 for 1 cycle -> all outputs 0 on the next edge.
- Pass-through: rst=0, en=1, select=1, all 1-bit inputs 1, fwd_a=fwd_b=2'b10 -> after one edge all 1-bit outputs are 1 and both fwd outputs are 2'b10.
- Bubble: same inputs with select=0 -> after one edge all outputs are 0, fwd outputs 2'b00.
- X select: select=1'bX, other inputs as in pass-through -> after one edge all outputs are 0 with no X.
- X data: select=1 with w_enable, r_i_sel_ctrl, rd_ctrl, fwd_dm_ctrl = X and fwd_a=2'bXX -> those outputs are X, the others are 1 and fwd_b=2'b10. Then select=0 with the same inputs -> all outputs are 0.
- Stall and stats: load pass-through, then en=0 with select=0 for 3 cycles -> outputs hold. With BUBLE_STAT_EN, 5 bubbles -> o_bubble_cnt=5, and rst clears it to 0.
